// File: rtl/sha256_sched_pkg.sv
// Shared constants, state encoding and sigma helpers for the SHA-256 message schedule.
// The op counter in the top level is enabled by SHA256_SCHED_OPCNT_EN.
package sha256_sched_pkg;

   localparam int WORDSIZE     = 32;
   localparam int ROUNDS       = 64;
   localparam int OPS_PER_WORD = 7;

   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational small-sigma of one schedule word: s0 when UPPER=0, s1 when UPPER=1.
module sha256_sched_sigma
   import sha256_sched_pkg::*;
#(
   parameter bit UPPER = 1'b0
) (
   input  logic [WORDSIZE-1:0] x,
   output logic [WORDSIZE-1:0] y
);

   generate
      if (UPPER) begin : g_s1
         assign y = s1(x);
      end else begin : g_s0
         assign y = s0(x);
      end
   endgenerate

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] with K[j].
// Optional op counter enabled by defining SHA256_SCHED_OPCNT_EN.
module sha256_msg_schedule
   import sha256_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_data,
   output logic [31:0] w_k,
   output logic [5:0]  w_idx,
   output logic        w_last,
   output logic        done,
   output logic [31:0] op_count
);

   state_t      state;
   logic [5:0]  j;
   logic [3:0]  cnt;
   logic [31:0] r [16];
   logic        done_q;
   logic [31:0] sig0, sig1, w_new;
   logic        in_hs, w_hs;

   sha256_sched_sigma #(.UPPER(1'b0)) u_s0 (.x(r[1]),  .y(sig0));
   sha256_sched_sigma #(.UPPER(1'b1)) u_s1 (.x(r[14]), .y(sig1));

   assign w_new = sig1 + r[9] + sig0 + r[0];

   assign in_ready = (state != EMIT);
   assign w_valid  = (state == EMIT);
   assign in_hs    = in_valid && in_ready;
   assign w_hs     = w_valid && w_ready;

   // Data outputs are forced to zero outside EMIT so reset/idle shows all-zero.
   assign w_data = w_valid ? r[0] : '0;
   assign w_k    = w_valid ? K[j] : '0;
   assign w_idx  = j;
   assign w_last = w_valid && (j == 6'(ROUNDS-1));
   assign done   = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         j      <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < 16; i++) r[i] <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state <= IDLE;
            j     <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE, LOAD: begin
                  if (in_hs) begin
                     for (int i = 0; i < 15; i++) r[i] <= r[i+1];
                     r[15] <= in_data;
                     cnt   <= cnt + 4'd1;
                     j     <= '0;
                     state <= (cnt == 4'd15) ? EMIT : LOAD;
                  end
               end
               EMIT: begin
                  if (w_hs) begin
                     // Words generated for j >= 48 land in r[] but are never emitted.
                     for (int i = 0; i < 15; i++) r[i] <= r[i+1];
                     r[15] <= w_new;
                     j     <= j + 6'd1;
                     if (j == 6'(ROUNDS-1)) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SHA256_SCHED_OPCNT_EN
   logic [31:0] op_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         op_cnt_q <= '0;
      else if (!flush && w_hs && (j <= 6'(ROUNDS-17)))
         op_cnt_q <= op_cnt_q + 32'(OPS_PER_WORD);
   end

   assign op_count = op_cnt_q;
`else
   assign op_count = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a plain SHA-256 schedule model.
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, w_ready;
   logic [31:0] in_data;
   logic        in_ready, w_valid, w_last, done;
   logic [31:0] w_data, w_k, op_count;
   logic [5:0]  w_idx;

   sha256_msg_schedule dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_k(w_k),
      .w_idx(w_idx), .w_last(w_last), .done(done), .op_count(op_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   int          errs = 0;
   int          checks = 0;
   logic [31:0] msg [16];
   logic [31:0] wexp [64];
   logic [31:0] got [64];
   logic [31:0] op_exp = 32'd0;
   int          last_acc_cyc = 0;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ss1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic compute_ref();
      for (int t = 0; t < 16; t++) wexp[t] = msg[t];
      for (int t = 16; t < 64; t++)
         wexp[t] = ss1(wexp[t-2]) + wexp[t-7] + ss0(wexp[t-15]) + wexp[t-16];
   endtask

   task automatic random_msg();
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      compute_ref();
   endtask

   // Call at a negedge; returns at the negedge after the 16th accept.
   task automatic load_block();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = msg[i];
         checks++;
         if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL load_ready word=%0d in_ready=%b want 1", i, in_ready);
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = '0;
      checks++;
      if (w_valid !== 1'b1 || w_idx !== 6'd0 || in_ready !== 1'b0) begin
         errs++;
         $display("FAIL load_latency w_valid=%b w_idx=%0d in_ready=%b want 1/0/0", w_valid, w_idx, in_ready);
      end
   endtask

   // Consume words with w_ready low low_pct% of cycles. At stop_idx, optionally flush together
   // with w_ready and return; otherwise run to the done cycle and return at that negedge.
   task automatic drain(input int low_pct, input int stop_idx, input bit do_flush);
      int          n = 0;
      int          budget = 0;
      bit          stalled = 0;
      bit          stop = 0;
      logic [31:0] pd, pk;
      logic [5:0]  pi;
      logic        pl;
      while (n < 64 && budget < 2000 && !stop) begin
         budget++;
         if (stalled) begin
            checks++;
            if (w_data !== pd || w_k !== pk || w_idx !== pi || w_last !== pl) begin
               errs++;
               $display("FAIL stall_hold got %h/%h/%0d/%b want %h/%h/%0d/%b", w_data, w_k, w_idx, w_last, pd, pk, pi, pl);
            end
         end
         if (w_valid !== 1'b1) begin
            checks++;
            errs++;
            $display("FAIL w_valid_bubble n=%0d w_valid=%b want 1", n, w_valid);
            stop = 1;
         end else if (n == stop_idx) begin
            stop = 1;
            if (do_flush) begin
               w_ready = 1'b1;
               flush   = 1'b1;
               @(posedge clk);
               @(negedge clk);
               flush   = 1'b0;
            end
            w_ready = 1'b0;
         end else begin
            w_ready = ($urandom_range(99) >= low_pct);
            if (w_ready) begin
               checks++;
               if (w_data !== wexp[n] || w_k !== KT[n] || w_idx !== 6'(n) || w_last !== (n == 63)) begin
                  errs++;
                  $display("FAIL word j=%0d got w=%h k=%h idx=%0d last=%b want w=%h k=%h idx=%0d last=%b",
                           n, w_data, w_k, w_idx, w_last, wexp[n], KT[n], n, (n == 63));
               end
               got[n] = w_data;
`ifdef SHA256_SCHED_OPCNT_EN
               if (n <= 47) op_exp = op_exp + 32'd7;
`endif
               if (n == 63) last_acc_cyc = cyc;
               n++;
               stalled = 0;
            end else begin
               stalled = 1;
               pd = w_data; pk = w_k; pi = w_idx; pl = w_last;
            end
            @(posedge clk);
            @(negedge clk);
         end
      end
      w_ready = 1'b0;
      if (!stop) begin
         checks++;
         if (n < 64) begin
            errs++;
            $display("FAIL drain_timeout words=%0d want 64", n);
         end else if (done !== 1'b1 || w_valid !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL done_cycle done=%b w_valid=%b in_ready=%b want 1/0/1", done, w_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; w_ready = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || w_valid !== 1'b0 || done !== 1'b0 || op_count !== 32'd0 ||
          w_data !== 32'd0 || w_k !== 32'd0 || w_idx !== 6'd0 || w_last !== 1'b0) begin
         errs++;
         $display("FAIL reset in_ready=%b w_valid=%b done=%b op=%0d w=%h k=%h idx=%0d last=%b want 1/0/0/0/0/0/0/0",
                  in_ready, w_valid, done, op_count, w_data, w_k, w_idx, w_last);
      end
   endtask

   task automatic test_abc();
      for (int i = 0; i < 16; i++) msg[i] = 32'd0;
      msg[0]  = 32'h61626380;
      msg[15] = 32'h00000018;
      compute_ref();
      load_block();
      checks++;
      if (w_data !== 32'h61626380 || w_k !== 32'h428a2f98) begin
         errs++;
         $display("FAIL abc_w0 got w=%h k=%h want 61626380/428a2f98", w_data, w_k);
      end
      drain(0, -1, 1'b0);
      checks++;
      if (got[16] !== 32'h61626380) begin
         errs++;
         $display("FAIL abc_w16 got %h want 61626380", got[16]);
      end
      checks++;
      if (got[17] !== 32'h000f0000) begin
         errs++;
         $display("FAIL abc_w17 got %h want 000f0000", got[17]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL abc_done_once done=%b want 0", done);
      end
   endtask

   task automatic test_backpressure();
      random_msg();
      load_block();
      drain(30, -1, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_opcount_two_blocks();
      checks++;
`ifdef SHA256_SCHED_OPCNT_EN
      if (op_count !== 32'd672) begin
         errs++;
         $display("FAIL opcnt_two_blocks got %0d want 672", op_count);
      end
`else
      if (op_count !== 32'd0) begin
         errs++;
         $display("FAIL opcnt_disabled got %0d want 0", op_count);
      end
`endif
   endtask

   task automatic test_back_to_back();
      random_msg();
      load_block();
      drain(0, -1, 1'b0);
      random_msg();
      load_block();
      checks++;
      if (cyc - last_acc_cyc != 17) begin
         errs++;
         $display("FAIL b2b_latency got %0d cycles want 17", cyc - last_acc_cyc);
      end
      drain(20, -1, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_flush();
      random_msg();
      load_block();
      drain(0, 20, 1'b1);
      checks++;
      if (w_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || w_idx !== 6'd0) begin
         errs++;
         $display("FAIL flush_state w_valid=%b in_ready=%b done=%b idx=%0d want 0/1/0/0", w_valid, in_ready, done, w_idx);
      end
      random_msg();
      load_block();
      drain(10, -1, 1'b0);
      @(negedge clk);
      checks++;
      if (op_count !== op_exp) begin
         errs++;
         $display("FAIL flush_opcnt got %0d want %0d", op_count, op_exp);
      end
   endtask

   task automatic test_async_reset();
      random_msg();
      load_block();
      drain(0, 10, 1'b0);
      #2 rst = 1'b1;
      #1;
      op_exp = 32'd0;
      checks++;
      if (w_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 32'd0 || w_idx !== 6'd0 ||
          w_data !== 32'd0 || w_k !== 32'd0 || done !== 1'b0) begin
         errs++;
         $display("FAIL async_rst w_valid=%b in_ready=%b op=%0d idx=%0d w=%h k=%h done=%b want 0/1/0/0/0/0/0",
                  w_valid, in_ready, op_count, w_idx, w_data, w_k, done);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      random_msg();
      load_block();
      drain(25, -1, 1'b0);
      @(negedge clk);
      checks++;
      if (op_count !== op_exp) begin
         errs++;
         $display("FAIL post_rst_opcnt got %0d want %0d", op_count, op_exp);
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_backpressure();
      test_opcount_two_blocks();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
